lmsm_sequencer: RTL and testbench
=================================

# lmsm_sequencer

Multi-cycle sequencer for the Load-Multiple / Store-Multiple instructions. It walks the 8-bit register-list immediate from the lowest set bit upward, issuing one memory transfer per set bit. Each transfer uses consecutive word addresses starting at the base address. The register list is consumed by clearing every bit up to and including the bit just served. The block sits between the main control FSM, the register file write port and the memory interface.

## Interface
Parameters:
- `AW`, 16: address / data-word width.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a sequence; honoured only in IDLE.
- `is_load` in 1: 1 = LM (memory to register file), 0 = SM; sampled with `start`.
- `imm8` in 8: register list; bit i set means register Ri is transferred; sampled with `start`.
- `base_addr` in AW: first transfer address; sampled with `start`.
- `mem_ack` in 1: memory completes the current transfer this cycle.
- `mem_req` out 1: transfer request, held until `mem_ack`.
- `mem_we` out 1: store strobe, `mem_req & ~is_load_q`.
- `mem_addr` out AW: address of the current transfer.
- `reg_idx` out 3: register of the current transfer, the lowest set bit of the remaining mask.
- `rf_we` out 1: register-file write, `mem_ack & mem_req & is_load_q`.
- `busy` out 1: high in XFER and DONE.
- `done` out 1: one-cycle completion pulse.
- `wb_addr` out AW: present only with LMSM_WRITEBACK_EN.
- `wb_we` out 1: present only with LMSM_WRITEBACK_EN.

## Operation
- Registers:
  - `mask_q[7:0]`
  - `addr_q[AW-1:0]`
  - `is_load_q`
  - `state` ∈ {IDLE, XFER, DONE}
- IDLE:
  - On `start` with `imm8 != 0`: latch `mask_q`, `addr_q`, `is_load_q`, then go to XFER.
  - On `start` with `imm8 == 0`: go directly to DONE. No memory request is made.
- XFER:
  - `mem_req` = 1.
  - `reg_idx` = priority encoding of `mask_q`, lowest set bit wins.
  - `mem_addr` = `addr_q`.
- On `mem_ack` in XFER:
  - Clear `mask_q` bits 0..`reg_idx` inclusive.
  - `addr_q` <= `addr_q` + 1, modulo 2^AW; 16'hFFFF wraps to 16'h0000.
  - If the cleared mask is zero, go to DONE. Otherwise stay in XFER; the next request is issued back-to-back on the following cycle.
- DONE:
  - `done` = 1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored. Latched values are not disturbed by input changes during a sequence.
- `mem_ack` outside XFER is ignored.
- `reset` low at any time, including mid-sequence:
  - State returns to IDLE immediately and asynchronously.
  - `mask_q` = 0 and `addr_q` = 0.
  - Any transfer in flight is abandoned, and no `done` pulse is produced.

## Timing
- Reset values:
  - `mem_req`, `mem_we`, `rf_we`, `busy`, `done` = 0.
  - `mem_addr` = 0, `reg_idx` = 0.
  - `wb_we` = 0, `wb_addr` = 0.
- Latency:
  - `start` at edge N puts the first `mem_req` high in cycle N+1.
  - With zero-wait acks and k set bits, `done` is in cycle N+k+1.
  - An empty list gives `done` in cycle N+1.
- `rf_we`, `reg_idx` and `mem_addr` are valid in the same cycle as `mem_ack`. Read data is written by the register file on that edge.
- A new `start` is accepted in the cycle after `done`, once the block is back in IDLE.

## Configuration
- `LMSM_WRITEBACK_EN` defined:
  - Adds `wb_addr` and `wb_we`.
  - In DONE, `wb_we` = 1 and `wb_addr` = final `addr_q` (base + number of transfers, modulo 2^AW). This gives base-register auto-increment.
  - For an empty list, `wb_addr` = `base_addr`.
- `LMSM_WRITEBACK_EN` undefined: the ports and the logic are absent. All other behaviour is identical.

## Test plan
- Load, zero-wait:
  - Stimulus: `imm8`=8'b10100101, `base_addr`=16'h0040, `is_load`=1, `mem_ack` tied high.
  - Required response: `reg_idx` 0,2,5,7 at addresses 16'h0040–16'h0043; `rf_we` high for 4 cycles; `done` 5 cycles after `start`; `wb_addr`=16'h0044.
- Store with wait states:
  - Stimulus: `imm8`=8'h81, `is_load`=0, each ack delayed 2 cycles.
  - Required response: `mem_req`/`mem_we` held steady with `reg_idx`=0, then `reg_idx`=7; `rf_we` never asserts; `done` after the second ack.
- Empty list:
  - Stimulus: `imm8`=0.
  - Required response: no `mem_req`; `done` 1 cycle after `start`; `busy` high for 1 cycle.
- Address wrap:
  - Stimulus: `imm8`=8'h03, `base_addr`=16'hFFFF.
  - Required response: addresses 16'hFFFF then 16'h0000; `wb_addr`=16'h0001.
- Mid-sequence disturbances:
  - Stimulus: `reset` pulled low during the second transfer of 8'hFF.
  - Required response: all outputs 0 at once; no `done`.
  - Stimulus: `start` pulsed again during a sequence.
  - Required response: the second `start` is ignored; the sequence completes unchanged.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - LM/SM register-list sequencer; optional base writeback under LMSM_WRITEBACK_EN
module lmsm_sequencer #(
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          start_i,
  input  logic          is_load_i,
  input  logic [7:0]    imm8_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic          mem_ack_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [2:0]    reg_idx_o,
  output logic          rf_we_o,
  output logic          busy_o,
`ifdef LMSM_WRITEBACK_EN
  output logic [AW-1:0] wb_addr_o,
  output logic          wb_we_o,
`endif
  output logic          done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mask_q, mask_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          is_load_q, is_load_d;
  logic [2:0]    idx;

  // Lowest set bit of the remaining list selects the register being served.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) idx = i[2:0];
    end
  end

  // Next-state logic: latch the request in IDLE, retire one list bit per ack in XFER.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    is_load_d = is_load_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          // Address is latched even for an empty list so writeback returns the base.
          mask_d    = imm8_i;
          addr_d    = base_addr_i;
          is_load_d = is_load_i;
          state_d   = (imm8_i != 8'd0) ? XFER : DONE;
        end
      end
      XFER: begin
        if (mem_ack_i) begin
          // Bits below idx are already zero, so clearing the lowest set bit
          // clears bits 0..idx inclusive.
          mask_d = mask_q & (mask_q - 8'd1);
          addr_d = addr_q + AW'(1);
          if (mask_d == 8'd0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any sequence in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      mask_q    <= 8'd0;
      addr_q    <= '0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      is_load_q <= is_load_d;
    end
  end

  // Outputs decoded from state; address and index are only driven during a transfer.
  always_comb begin
    mem_req_o  = (state_q == XFER);
    mem_we_o   = mem_req_o & ~is_load_q;
    mem_addr_o = mem_req_o ? addr_q : '0;
    reg_idx_o  = mem_req_o ? idx : 3'd0;
    rf_we_o    = mem_ack_i & mem_req_o & is_load_q;
    busy_o     = (state_q == XFER) || (state_q == DONE);
    done_o     = (state_q == DONE);
`ifdef LMSM_WRITEBACK_EN
    wb_we_o    = done_o;
    wb_addr_o  = done_o ? addr_q : '0;
`endif
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb/tb_lmsm_sequencer.sv - directed self-checking bench for lmsm_sequencer
module tb_lmsm_sequencer;

  localparam int AW = 16;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          is_load;
  logic [7:0]    imm8;
  logic [AW-1:0] base_addr;
  logic          mem_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [2:0]    reg_idx;
  logic          rf_we;
  logic          busy;
  logic          done;
`ifdef LMSM_WRITEBACK_EN
  logic [AW-1:0] wb_addr;
  logic          wb_we;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  lmsm_sequencer #(.AW(AW)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .start_i     (start),
    .is_load_i   (is_load),
    .imm8_i      (imm8),
    .base_addr_i (base_addr),
    .mem_ack_i   (mem_ack),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .reg_idx_o   (reg_idx),
    .rf_we_o     (rf_we),
    .busy_o      (busy),
`ifdef LMSM_WRITEBACK_EN
    .wb_addr_o   (wb_addr),
    .wb_we_o     (wb_we),
`endif
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".req"},  32'(mem_req),  32'd0);
    check({tag, ".we"},   32'(mem_we),   32'd0);
    check({tag, ".rfwe"}, 32'(rf_we),    32'd0);
    check({tag, ".busy"}, 32'(busy),     32'd0);
    check({tag, ".done"}, 32'(done),     32'd0);
    check({tag, ".addr"}, 32'(mem_addr), 32'd0);
    check({tag, ".idx"},  32'(reg_idx),  32'd0);
`ifdef LMSM_WRITEBACK_EN
    check({tag, ".wbwe"}, 32'(wb_we),    32'd0);
    check({tag, ".wba"},  32'(wb_addr),  32'd0);
`endif
  endtask

  task automatic check_xfer(input string tag, input logic [2:0] idx, input logic [15:0] addr,
                            input logic we, input logic rfwe);
    check({tag, ".req"},  32'(mem_req),  32'd1);
    check({tag, ".idx"},  32'(reg_idx),  32'(idx));
    check({tag, ".addr"}, 32'(mem_addr), 32'(addr));
    check({tag, ".we"},   32'(mem_we),   32'(we));
    check({tag, ".rfwe"}, 32'(rf_we),    32'(rfwe));
    check({tag, ".busy"}, 32'(busy),     32'd1);
    check({tag, ".done"}, 32'(done),     32'd0);
  endtask

  task automatic check_done(input string tag, input logic [15:0] wba);
    check({tag, ".done"}, 32'(done),    32'd1);
    check({tag, ".busy"}, 32'(busy),    32'd1);
    check({tag, ".req"},  32'(mem_req), 32'd0);
    check({tag, ".rfwe"}, 32'(rf_we),   32'd0);
`ifdef LMSM_WRITEBACK_EN
    check({tag, ".wbwe"}, 32'(wb_we),   32'd1);
    check({tag, ".wba"},  32'(wb_addr), 32'(wba));
`else
    if (wba == 16'hDEAD) $display("unused writeback address");
`endif
  endtask

  task automatic issue(input logic [7:0] list, input logic [15:0] base, input logic ld);
    imm8 = list;
    base_addr = base;
    is_load = ld;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [2:0] idx_a5 [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    logic [2:0] idx_81 [2] = '{3'd0, 3'd7};

    reset_n = 1'b0;
    start = 1'b0;
    is_load = 1'b0;
    imm8 = 8'd0;
    base_addr = '0;
    mem_ack = 1'b0;
    tick();
    check_idle("reset");
    reset_n = 1'b1;
    tick();
    check_idle("idle");

    // Load, zero-wait acks
    mem_ack = 1'b1;
    check("idle_ack.rfwe", 32'(rf_we), 32'd0);
    issue(8'b1010_0101, 16'h0040, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_xfer($sformatf("ld%0d", i), idx_a5[i], 16'h0040 + 16'(i), 1'b0, 1'b1);
      tick();
    end
    check_done("ld_done", 16'h0044);
    tick();
    check_idle("ld_after");

    // Store, two wait cycles before each ack
    mem_ack = 1'b0;
    issue(8'h81, 16'h0100, 1'b0);
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 2; w++) begin
        check_xfer($sformatf("st%0d_w%0d", i, w), idx_81[i], 16'h0100 + 16'(i), 1'b1, 1'b0);
        tick();
      end
      mem_ack = 1'b1;
      check_xfer($sformatf("st%0d_ack", i), idx_81[i], 16'h0100 + 16'(i), 1'b1, 1'b0);
      tick();
      mem_ack = 1'b0;
    end
    check_done("st_done", 16'h0102);
    tick();
    check_idle("st_after");

    // Empty list
    issue(8'h00, 16'h1234, 1'b1);
    check_done("empty_done", 16'h1234);
    tick();
    check_idle("empty_after");

    // Address wrap
    mem_ack = 1'b1;
    issue(8'h03, 16'hFFFF, 1'b1);
    check_xfer("wrap0", 3'd0, 16'hFFFF, 1'b0, 1'b1);
    tick();
    check_xfer("wrap1", 3'd1, 16'h0000, 1'b0, 1'b1);
    tick();
    check_done("wrap_done", 16'h0001);
    tick();
    check_idle("wrap_after");

    // Reset during the second transfer of a full list
    issue(8'hFF, 16'h0300, 1'b1);
    check_xfer("rst0", 3'd0, 16'h0300, 1'b0, 1'b1);
    tick();
    check_xfer("rst1", 3'd1, 16'h0301, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("rst_now");
    tick();
    check_idle("rst_hold");
    reset_n = 1'b1;
    tick();
    check_idle("rst_rel");
    tick();
    check_idle("rst_rel2");

    // Second start during a sequence is ignored
    issue(8'h06, 16'h0200, 1'b1);
    check_xfer("rs0", 3'd1, 16'h0200, 1'b0, 1'b1);
    imm8 = 8'h01;
    base_addr = 16'h0999;
    is_load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_xfer("rs1", 3'd2, 16'h0201, 1'b0, 1'b1);
    tick();
    check_done("rs_done", 16'h0202);
    tick();
    check_idle("rs_after");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
